// File: rtl/fx_pkg.sv
// fx_pkg: shared types and defaults for the effects-unit transmit scheduler
`timescale 1ns/1ps
package fx_pkg;
  localparam int DATA_W = 8;
  localparam int FIFO_DEPTH_DEF = 8;
  localparam int BUSY_TIMEOUT_DEF = 16;
  typedef enum logic [1:0] {S_IDLE, S_WAIT_BUSY, S_WAIT_DONE} state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with combinational head read and occupancy count
`timescale 1ns/1ps
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = level == (AW+1)'(DEPTH);
  assign empty = level == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign data = mem[rd_ptr];
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  // storage needs no reset; only the pointers define validity
  always_ff @(posedge i_clk)
    if (do_push) mem[wr_ptr] <= wr_data;
endmodule

// File: rtl/fx_tx_sched.sv
// fx_tx_sched: arbitrates sample FIFO and control byte onto a single UART transmitter
`timescale 1ns/1ps
module fx_tx_sched import fx_pkg::*; #(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_smp_dv,
  input  logic [DATA_W-1:0]             i_smp_byte,
  input  logic                          i_ctl_valid,
  input  logic [DATA_W-1:0]             i_ctl_byte,
  output logic                          o_ctl_ready,
  input  logic                          i_tx_active,
  output logic                          o_tx_dv,
  output logic [DATA_W-1:0]             o_tx_byte,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_ovf,
  input  logic                          i_ovf_clr,
  output logic                          o_tx_err
);
  localparam int CW = $clog2(BUSY_TIMEOUT+1);
  state_t state, state_nxt;
  logic ctl_pend, last_ctl, grant, sel_ctl, pop, push, timeout;
  logic fifo_full, fifo_empty;
  logic [DATA_W-1:0] ctl_byte, fifo_data;
  logic [CW-1:0] cnt;
  sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .push(push), .pop(pop), .wr_data(i_smp_byte),
    .data(fifo_data), .level(o_level), .full(fifo_full), .empty(fifo_empty)
  );
  assign o_ctl_ready = !ctl_pend;
  // grant decision, round-robin source select and next state
  always_comb begin
    sel_ctl = ctl_pend && (fifo_empty || !last_ctl);
    grant = state == S_IDLE && (ctl_pend || !fifo_empty) && !i_tx_active;
    pop = grant && !sel_ctl;
    push = i_smp_dv && (!fifo_full || pop);
    timeout = state == S_WAIT_BUSY && !i_tx_active && cnt == CW'(BUSY_TIMEOUT-1);
    state_nxt = state;
    unique case (state)
      S_IDLE:      state_nxt = grant ? S_WAIT_BUSY : S_IDLE;
      S_WAIT_BUSY: state_nxt = i_tx_active ? S_WAIT_DONE : timeout ? S_IDLE : S_WAIT_BUSY;
      S_WAIT_DONE: state_nxt = i_tx_active ? S_WAIT_DONE : S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end
  // state register
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= S_IDLE;
    else state <= state_nxt;
  // launch strobe, held byte and round-robin memory; reset favours samples first
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_tx_dv <= 1'b0;
      o_tx_byte <= '0;
      last_ctl <= 1'b1;
    end else begin
      o_tx_dv <= grant;
      if (grant) begin
        o_tx_byte <= sel_ctl ? ctl_byte : fifo_data;
        last_ctl <= sel_ctl;
      end
    end
  // control holding register, freed when its byte is granted
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      ctl_pend <= 1'b0;
      ctl_byte <= '0;
    end else if (grant && sel_ctl) ctl_pend <= 1'b0;
    else if (i_ctl_valid && !ctl_pend) begin
      ctl_pend <= 1'b1;
      ctl_byte <= i_ctl_byte;
    end
  // cycles spent waiting for the transmitter to report busy
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) cnt <= '0;
    else cnt <= state == S_WAIT_BUSY ? cnt + CW'(1) : '0;
  // sticky error flags; a new event beats a simultaneous clear
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_ovf <= 1'b0;
      o_tx_err <= 1'b0;
    end else begin
      o_ovf <= (i_smp_dv && !push) ? 1'b1 : i_ovf_clr ? 1'b0 : o_ovf;
      o_tx_err <= timeout ? 1'b1 : i_ovf_clr ? 1'b0 : o_tx_err;
    end
endmodule

// File: tb/tb_fx_tx_sched.sv
// tb_fx_tx_sched: directed checks of the transmit scheduler against a simple UART model
`timescale 1ns/1ps
module tb_fx_tx_sched;
  import fx_pkg::*;
  logic clk = 0, rst_n = 0, smp_dv = 0, ctl_valid = 0, ovf_clr = 0;
  logic [7:0] smp_byte = 0, ctl_byte = 0, tx_byte;
  logic tx_active, ctl_ready, tx_dv, ovf, tx_err;
  logic [3:0] level;
  logic hold = 0, mute = 0, busy = 0;
  int bcnt = 0;
  logic [7:0] log_q[$];
  int checks = 0, errors = 0;
  always #10 clk = ~clk;
  assign tx_active = busy | hold;
  fx_tx_sched dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_smp_dv(smp_dv), .i_smp_byte(smp_byte),
    .i_ctl_valid(ctl_valid), .i_ctl_byte(ctl_byte), .o_ctl_ready(ctl_ready),
    .i_tx_active(tx_active), .o_tx_dv(tx_dv), .o_tx_byte(tx_byte), .o_level(level),
    .o_ovf(ovf), .i_ovf_clr(ovf_clr), .o_tx_err(tx_err)
  );
  // UART model: busy for a few cycles after each strobe, logs launched bytes
  always @(posedge clk)
    if (tx_dv && !mute) begin
      log_q.push_back(tx_byte);
      busy <= 1'b1;
      bcnt <= 3;
    end else if (bcnt > 0) bcnt <= bcnt - 1;
    else busy <= 1'b0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [7:0] b);
    smp_dv = 1; smp_byte = b;
    step();
    smp_dv = 0;
  endtask
  task automatic wait_log(input int n, input string tag);
    int k = 0;
    while (log_q.size() < n && k < 200) begin step(); k++; end
    chk(tag, log_q.size(), n);
  endtask
  task automatic do_reset;
    rst_n = 0;
    step(2);
    rst_n = 1;
    step();
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_level"}, level, 0);
    chk({tag, "_tx_dv"}, tx_dv, 0);
    chk({tag, "_tx_byte"}, tx_byte, 8'h00);
    chk({tag, "_ctl_ready"}, ctl_ready, 1);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_tx_err"}, tx_err, 0);
  endtask
  initial begin
    int k, n;
    step(2);
    chk_reset("rst");
    rst_n = 1;
    step();
    // single sample latency
    smp_dv = 1; smp_byte = 8'hA5;
    step();
    smp_dv = 0;
    chk("lat_n1_dv", tx_dv, 0);
    chk("lat_n1_level", level, 1);
    step();
    chk("lat_n2_dv", tx_dv, 1);
    chk("lat_n2_byte", tx_byte, 8'hA5);
    chk("lat_n2_level", level, 0);
    wait_log(1, "lat_log");
    step(10);
    log_q.delete();
    // burst overflow while transmitter busy
    hold = 1;
    for (int i = 0; i < 10; i++) push(8'(i));
    chk("burst_level", level, 8);
    chk("burst_ovf", ovf, 1);
    ovf_clr = 0;
    smp_dv = 1; smp_byte = 8'hEE; ovf_clr = 1;
    step();
    smp_dv = 0; ovf_clr = 0;
    chk("ovf_set_wins", ovf, 1);
    ovf_clr = 1;
    step();
    ovf_clr = 0;
    chk("ovf_clr", ovf, 0);
    hold = 0;
    wait_log(8, "burst_log");
    step(20);
    chk("burst_cnt", log_q.size(), 8);
    for (int i = 0; i < 8 && i < log_q.size(); i++) chk($sformatf("burst_ord%0d", i), log_q[i], 8'(i));
    chk("burst_drained", level, 0);
    log_q.delete();
    // full FIFO with push and pop in the same cycle
    hold = 1;
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    chk("full_level", level, 8);
    hold = 0; smp_dv = 1; smp_byte = 8'h18;
    step();
    smp_dv = 0;
    chk("pp_dv", tx_dv, 1);
    chk("pp_level", level, 8);
    chk("pp_ovf", ovf, 0);
    wait_log(9, "pp_log");
    for (int i = 0; i < 9 && i < log_q.size(); i++) chk($sformatf("pp_ord%0d", i), log_q[i], 8'h10 + 8'(i));
    step(10);
    // busy timeout
    mute = 1;
    push(8'h55);
    k = 0;
    while (!tx_dv && k < 10) begin step(); k++; end
    chk("to_launch", tx_dv, 1);
    n = 0;
    while (!tx_err && n < 40) begin step(); n++; end
    chk("to_cycles", n, 16);
    chk("to_idle", dut.state, S_IDLE);
    ovf_clr = 1;
    step();
    ovf_clr = 0;
    chk("to_clr", tx_err, 0);
    mute = 0;
    // round-robin from reset
    do_reset();
    log_q.delete();
    hold = 1;
    push(8'hB1); push(8'hB2); push(8'hB3);
    ctl_valid = 1; ctl_byte = 8'h7E;
    step();
    ctl_valid = 0;
    chk("rr_ctl_busy", ctl_ready, 0);
    hold = 0;
    wait_log(4, "rr_log");
    step(10);
    if (log_q.size() >= 4) begin
      chk("rr_0", log_q[0], 8'hB1);
      chk("rr_1", log_q[1], 8'h7E);
      chk("rr_2", log_q[2], 8'hB2);
      chk("rr_3", log_q[3], 8'hB3);
    end
    chk("rr_ctl_ready", ctl_ready, 1);
    // reset during S_WAIT_DONE with bytes queued
    do_reset();
    log_q.delete();
    push(8'hC0);
    step(3);
    hold = 1;
    push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
    chk("mid_level", level, 4);
    chk("mid_state", dut.state, S_WAIT_DONE);
    rst_n = 0;
    #2;
    chk_reset("mid_rst");
    step();
    rst_n = 1;
    hold = 0;
    log_q.delete();
    step();
    chk("post_rst_dv", tx_dv, 0);
    step(30);
    chk("post_rst_none", log_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fx_tx_sched.md
FX_TX_SCHED -- requirements
Module: fx_tx_sched

Interface
REQ-001 Parameter FIFO_DEPTH, 8, sample FIFO entries; power of two, 2..64.
REQ-002 Parameter BUSY_TIMEOUT, 16, max cycles to wait for i_tx_active rise after launch.
REQ-003 i_clk  in  1  system clock, 50 MHz.
REQ-004 i_rst_n  in  1  reset; asynchronous, active-low.
REQ-005 i_smp_dv  in  1  one-cycle strobe, processed sample byte valid (from effect mux).
REQ-006 i_smp_byte  in  8  processed sample byte.
REQ-007 i_ctl_valid  in  1  control/status byte request (valid/ready).
REQ-008 i_ctl_byte  in  8  control/status byte.
REQ-009 o_ctl_ready  out  1  control holding register empty.
REQ-010 i_tx_active  in  1  UART transmitter busy.
REQ-011 o_tx_dv  out  1  one-cycle launch strobe to UART transmitter.
REQ-012 o_tx_byte  out  8  byte to transmit; stable from o_tx_dv until i_tx_active falls.
REQ-013 o_level  out  $clog2(FIFO_DEPTH)+1  sample FIFO occupancy.
REQ-014 o_ovf  out  1  sticky: a sample was dropped.
REQ-015 i_ovf_clr  in  1  one-cycle clear of o_ovf.
REQ-016 o_tx_err  out  1  sticky: BUSY_TIMEOUT expired; cleared by i_ovf_clr.

Function
REQ-017 Sample push accepted iff i_smp_dv and (o_level < FIFO_DEPTH or a pop occurs same cycle); else byte dropped, o_ovf set next cycle.
REQ-018 Simultaneous push and pop: o_level unchanged; FIFO order strictly preserved.
REQ-019 Control byte loaded when i_ctl_valid && o_ctl_ready; o_ctl_ready low from next cycle until that byte is launched, high again the cycle after launch.
REQ-020 FSM states: S_IDLE, S_WAIT_BUSY, S_WAIT_DONE.
REQ-021 S_IDLE: if (control pending or FIFO non-empty) and !i_tx_active -> grant, register o_tx_byte, pulse o_tx_dv, pop/clear source, go S_WAIT_BUSY; else stay.
REQ-022 S_WAIT_BUSY: i_tx_active=1 -> S_WAIT_DONE; counter reaches BUSY_TIMEOUT -> set o_tx_err, go S_IDLE.
REQ-023 S_WAIT_DONE: i_tx_active=0 -> S_IDLE.
REQ-024 Arbitration round-robin: when both control and sample pending, grant the source not granted last; single pending source always granted.
REQ-025 Latency: idle scheduler, empty FIFO, tx idle, i_smp_dv in cycle N -> o_tx_dv high in cycle N+2.
REQ-026 o_tx_dv never asserted outside S_IDLE exit; never two strobes without an intervening S_WAIT_DONE or timeout.
REQ-027 i_ovf_clr same cycle as new overflow: set wins.
REQ-028 FIFO pointers wrap modulo FIFO_DEPTH; o_level counts 0..FIFO_DEPTH inclusive.

Reset
REQ-029 Asynchronous assert: state S_IDLE, FIFO emptied, o_level=0, o_tx_dv=0, o_tx_byte=8'h00, o_ctl_ready=1, o_ovf=0, o_tx_err=0, round-robin pointer = control-last (sample favoured first).
REQ-030 Reset mid-transmission abandons the byte; no o_tx_dv in the first cycle after deassertion.

Structure
REQ-031 Package fx_pkg holds the state enum type, DATA_W=8, and default FIFO_DEPTH/BUSY_TIMEOUT constants.
REQ-032 Sample buffer is a sub-module sync_fifo (push, pop, data, level, full, empty), parameterised by width and depth.

Verification
REQ-033 Single sample 8'hA5, tx idle -> o_tx_dv at N+2 with o_tx_byte=8'hA5; o_level returns 0.
REQ-034 Burst of 10 samples 8'h00..8'h09 while i_tx_active held high, FIFO_DEPTH=8 -> o_level=8, o_ovf=1, transmitted order 8'h00..8'h07 only.
REQ-035 Control 8'h7E and 3 pending samples -> launch order sample, ctl, sample, sample; o_ctl_ready high after ctl launch.
REQ-036 Full FIFO plus push and pop same cycle -> push accepted, o_level stays 8, o_ovf stays 0.
REQ-037 Launch with i_tx_active never rising -> o_tx_err=1 after BUSY_TIMEOUT cycles, FSM back to S_IDLE; i_ovf_clr clears it.
REQ-038 i_rst_n pulsed low during S_WAIT_DONE with 4 queued -> all outputs at reset values, no stale byte transmitted afterwards.
